// File: rtl/wb_arbiter_pkg.sv
// Shared widths, the hard-wired zero register and the write-back request layout.
package wb_arbiter_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int REG_ZERO   = 0;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] wa;
    logic [DATA_W_DEF-1:0] wd;
  } wb_req_t;

endpackage

// File: rtl/wb_arbiter_fifo.sv
// Synchronous FIFO buffering long-unit results; zero-latency head via dout.
// Pushes when full and pops when empty are ignored.
module wb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Merges pipeline write-back (priority) and buffered long-unit results onto one
// register-file write port, one-cycle latency; tracks pending long-op destinations.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pipe_we,
  input  logic [ADDR_W-1:0]    pipe_wa,
  input  logic [DATA_W-1:0]    pipe_wd,
  output logic                 pipe_stall,
  input  logic                 lu_valid,
  output logic                 lu_ready,
  input  logic [ADDR_W-1:0]    lu_wa,
  input  logic [DATA_W-1:0]    lu_wd,
  input  logic                 iss_valid,
  input  logic [ADDR_W-1:0]    iss_wa,
  output logic                 iss_ready,
  output logic [2**ADDR_W-1:0] busy,
  output logic                 regwrite,
  output logic [ADDR_W-1:0]    wa,
  output logic [DATA_W-1:0]    wd
);

  localparam int                REQ_W  = ADDR_W + DATA_W;
  localparam int                CW     = $clog2(FIFO_DEPTH) + 1;
  localparam int                SW     = $clog2(STARVE_MAX + 1);
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic [REQ_W-1:0]    fifo_dout;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CW-1:0]       fifo_count;
  logic                fifo_push;
  logic                pipe_sel;
  logic                pop;
  logic                iss_set;
  logic [ADDR_W-1:0]   head_wa;
  logic [DATA_W-1:0]   head_wd;
  logic [SW-1:0]       starve_cnt;
  logic [2**ADDR_W-1:0] busy_nxt;

  // Readiness comes from the registered occupancy only, so a same-cycle pop
  // never opens a combinational path from the write port back to the source.
  assign lu_ready  = (fifo_count < CW'(FIFO_DEPTH)) && rst_n;
  assign fifo_push = lu_valid && lu_ready && !fifo_full && (lu_wa != ZERO_A);

  assign head_wa   = fifo_dout[DATA_W +: ADDR_W];
  assign head_wd   = fifo_dout[DATA_W-1:0];

  assign pipe_sel  = pipe_we && (pipe_wa != ZERO_A);
  assign pop       = !pipe_sel && !fifo_empty;

  assign iss_ready = !busy[iss_wa] && rst_n;
  assign iss_set   = iss_valid && iss_ready && (iss_wa != ZERO_A);

  wb_fifo #(
    .W     (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (pop),
    .din   ({lu_wa, lu_wd}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A new issue to the register being retired this cycle must stay pending.
  always_comb begin
    busy_nxt = busy;
    if (pop)     busy_nxt[head_wa] = 1'b0;
    if (iss_set) busy_nxt[iss_wa]  = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regwrite   <= 1'b0;
      wa         <= '0;
      wd         <= '0;
      busy       <= '0;
      starve_cnt <= '0;
      pipe_stall <= 1'b0;
    end else begin
      regwrite <= pipe_sel || pop;
      if (pipe_sel) begin
        wa <= pipe_wa;
        wd <= pipe_wd;
      end else if (pop) begin
        wa <= head_wa;
        wd <= head_wd;
      end
      busy <= busy_nxt;

      if (pop || fifo_empty) begin
        starve_cnt <= '0;
      end else if (starve_cnt != SW'(STARVE_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      if (pop) begin
        pipe_stall <= 1'b0;
      end else if (starve_cnt >= SW'(STARVE_MAX - 1)) begin
        pipe_stall <= 1'b1;
      end
    end
  end

endmodule
